// File: rtl/bt656_tx_gen.sv
// BT.656-style 8-bit transmit pattern generator.
// Emits one byte per clock. Each line is EAV, horizontal blanking fill, SAV and payload.
// Vertical blanking lines (V=1) come first, then active lines (V=0). The field bit is always 0.
// Active payload is a deterministic XOR test pattern. Every output is a flop.
// Output flops are loaded from the *next* FSM position, so the byte on data_o always
// matches the current state registers.
module bt656_tx_gen #(
    parameter int CNT_W  = 11,
    parameter int FCNT_W = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              cfg_enable_i,
    input  logic [CNT_W-1:0]  cfg_line_len_i,
    input  logic [CNT_W-1:0]  cfg_lines_i,
    input  logic [7:0]        cfg_hblank_i,
    input  logic [7:0]        cfg_vblank_i,
    input  logic              cfg_emb_frame_cnt_i,
    output logic [7:0]        data_o,
    output logic              href_o,
    output logic              vsync_o,
    output logic [FCNT_W-1:0] frame_cnt_o,
    output logic              busy_o
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_EAV     = 3'd1,
        ST_HBLANK  = 3'd2,
        ST_SAV     = 3'd3,
        ST_PAYLOAD = 3'd4
    } state_t;

    // Timing reference XY byte: {1, F, V, H, V^H, F^H, F^V, F^V^H}, with F fixed at 0.
    function automatic logic [7:0] timing_xy(input logic v, input logic h);
        logic f;
        f = 1'b0;
        return {1'b1, f, v, h, v ^ h, f ^ h, f ^ v, f ^ v ^ h};
    endfunction

    // Keep the reserved values 0x00 and 0xFF out of the payload.
    function automatic logic [7:0] clamp_payload(input logic [7:0] b);
        logic [7:0] r;
        if (b == 8'h00) begin
            r = 8'h01;
        end else if (b == 8'hFF) begin
            r = 8'hFE;
        end else begin
            r = b;
        end
        return r;
    endfunction

    // The line length is forced even (4:2:2 pairs), and the minimum is one pair.
    function automatic logic [CNT_W-1:0] clamp_len(input logic [CNT_W-1:0] l);
        logic [CNT_W-1:0] e;
        e = l & ~CNT_W'(1);
        if (e < CNT_W'(2)) begin
            e = CNT_W'(2);
        end else begin
            e = e;
        end
        return e;
    endfunction

    // A frame always has at least one active line.
    function automatic logic [CNT_W-1:0] clamp_lines(input logic [CNT_W-1:0] n);
        logic [CNT_W-1:0] r;
        if (n == CNT_W'(0)) begin
            r = CNT_W'(1);
        end else begin
            r = n;
        end
        return r;
    endfunction

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   byte_q, byte_d;     // position inside the current state
    logic [CNT_W-1:0]   line_q, line_d;     // line index inside the vblank or active section
    logic               vblk_q, vblk_d;     // current line is a vertical blanking line
    logic [CNT_W-1:0]   len_q, len_d;
    logic [CNT_W-1:0]   lines_q, lines_d;
    logic [7:0]         hbl_q, hbl_d;
    logic [7:0]         vbl_q, vbl_d;
    logic               emb_q, emb_d;
    logic [FCNT_W-1:0]  fcnt_q, fcnt_d;
    logic [7:0]         data_q, data_d;
    logic               href_q, href_d;
    logic               vsync_q, vsync_d;
    logic               busy_q, busy_d;

    logic               start_s;        // a frame begins in the next cycle; relatch config
    logic               start_vblk_s;
    logic [CNT_W-1:0]   hbl_ext_s;
    logic [CNT_W-1:0]   vbl_ext_s;
    logic [7:0]         pattern_s;

    assign start_vblk_s = (cfg_vblank_i != 8'd0);
    assign hbl_ext_s    = {{(CNT_W-8){1'b0}}, hbl_q};
    assign vbl_ext_s    = {{(CNT_W-8){1'b0}}, vbl_q};

    // Next-state logic: advance the byte and line position through EAV/HBLANK/SAV/PAYLOAD.
    always_comb begin
        state_d = state_q;
        byte_d  = byte_q;
        line_d  = line_q;
        vblk_d  = vblk_q;
        start_s = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (cfg_enable_i) begin
                    start_s = 1'b1;
                    state_d = ST_EAV;
                    byte_d  = CNT_W'(0);
                    line_d  = CNT_W'(0);
                    vblk_d  = start_vblk_s;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_EAV: begin
                if (byte_q == CNT_W'(3)) begin
                    byte_d = CNT_W'(0);
                    if (hbl_q == 8'd0) begin
                        state_d = ST_SAV;
                    end else begin
                        state_d = ST_HBLANK;
                    end
                end else begin
                    byte_d = byte_q + CNT_W'(1);
                end
            end
            ST_HBLANK: begin
                if (byte_q + CNT_W'(1) == hbl_ext_s) begin
                    byte_d  = CNT_W'(0);
                    state_d = ST_SAV;
                end else begin
                    byte_d = byte_q + CNT_W'(1);
                end
            end
            ST_SAV: begin
                if (byte_q == CNT_W'(3)) begin
                    byte_d  = CNT_W'(0);
                    state_d = ST_PAYLOAD;
                end else begin
                    byte_d = byte_q + CNT_W'(1);
                end
            end
            ST_PAYLOAD: begin
                if (byte_q + CNT_W'(1) == len_q) begin
                    byte_d = CNT_W'(0);
                    if (vblk_q) begin
                        state_d = ST_EAV;
                        if (line_q + CNT_W'(1) == vbl_ext_s) begin
                            vblk_d = 1'b0;
                            line_d = CNT_W'(0);
                        end else begin
                            line_d = line_q + CNT_W'(1);
                        end
                    end else if (line_q + CNT_W'(1) == lines_q) begin
                        // End of frame: enable is sampled here for a zero-gap restart.
                        line_d = CNT_W'(0);
                        if (cfg_enable_i) begin
                            start_s = 1'b1;
                            state_d = ST_EAV;
                            vblk_d  = start_vblk_s;
                        end else begin
                            state_d = ST_IDLE;
                            vblk_d  = 1'b0;
                        end
                    end else begin
                        state_d = ST_EAV;
                        line_d  = line_q + CNT_W'(1);
                    end
                end else begin
                    byte_d = byte_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                byte_d  = CNT_W'(0);
                line_d  = CNT_W'(0);
                vblk_d  = 1'b0;
            end
        endcase
    end

    // Configuration shadow: captured only when a frame starts, then held for the whole frame.
    always_comb begin
        if (start_s) begin
            len_d   = clamp_len(cfg_line_len_i);
            lines_d = clamp_lines(cfg_lines_i);
            hbl_d   = cfg_hblank_i;
            vbl_d   = cfg_vblank_i;
            emb_d   = cfg_emb_frame_cnt_i;
        end else begin
            len_d   = len_q;
            lines_d = lines_q;
            hbl_d   = hbl_q;
            vbl_d   = vbl_q;
            emb_d   = emb_q;
        end
    end

    // Active payload byte for the next position: an XOR pattern, optionally with the frame count embedded.
    always_comb begin
        pattern_s = clamp_payload(byte_d[7:0] ^ line_d[7:0]);
        if (emb_d && (line_d == CNT_W'(0)) && (byte_d == CNT_W'(0))) begin
            pattern_s = clamp_payload(fcnt_q[15:8]);
        end else if (emb_d && (line_d == CNT_W'(0)) && (byte_d == CNT_W'(1))) begin
            pattern_s = clamp_payload(fcnt_q[7:0]);
        end else begin
            pattern_s = pattern_s;
        end
    end

    // Output decode for the next position, and the frame counter bump on the last payload byte.
    always_comb begin
        data_d  = 8'h00;
        href_d  = 1'b0;
        vsync_d = 1'b0;
        busy_d  = (state_d != ST_IDLE);
        case (state_d)
            ST_IDLE: begin
                data_d = 8'h00;
            end
            ST_EAV: begin
                vsync_d = vblk_d;
                case (byte_d[1:0])
                    2'd0:    data_d = 8'hFF;
                    2'd3:    data_d = timing_xy(vblk_d, 1'b1);
                    default: data_d = 8'h00;
                endcase
            end
            ST_SAV: begin
                vsync_d = vblk_d;
                case (byte_d[1:0])
                    2'd0:    data_d = 8'hFF;
                    2'd3:    data_d = timing_xy(vblk_d, 1'b0);
                    default: data_d = 8'h00;
                endcase
            end
            ST_HBLANK: begin
                vsync_d = vblk_d;
                data_d  = byte_d[0] ? 8'h10 : 8'h80;
            end
            ST_PAYLOAD: begin
                vsync_d = vblk_d;
                if (vblk_d) begin
                    data_d = byte_d[0] ? 8'h10 : 8'h80;
                end else begin
                    data_d = pattern_s;
                    href_d = 1'b1;
                end
            end
            default: begin
                data_d = 8'h00;
            end
        endcase

        if ((state_d == ST_PAYLOAD) && !vblk_d &&
            (byte_d + CNT_W'(1) == len_d) && (line_d + CNT_W'(1) == lines_d)) begin
            fcnt_d = fcnt_q + FCNT_W'(1);
        end else begin
            fcnt_d = fcnt_q;
        end
    end

    // State, config shadow, counter and output registers, with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            byte_q  <= '0;
            line_q  <= '0;
            vblk_q  <= 1'b0;
            len_q   <= '0;
            lines_q <= '0;
            hbl_q   <= 8'd0;
            vbl_q   <= 8'd0;
            emb_q   <= 1'b0;
            fcnt_q  <= '0;
            data_q  <= 8'h00;
            href_q  <= 1'b0;
            vsync_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            byte_q  <= byte_d;
            line_q  <= line_d;
            vblk_q  <= vblk_d;
            len_q   <= len_d;
            lines_q <= lines_d;
            hbl_q   <= hbl_d;
            vbl_q   <= vbl_d;
            emb_q   <= emb_d;
            fcnt_q  <= fcnt_d;
            data_q  <= data_d;
            href_q  <= href_d;
            vsync_q <= vsync_d;
            busy_q  <= busy_d;
        end
    end

    assign data_o      = data_q;
    assign href_o      = href_q;
    assign vsync_o     = vsync_q;
    assign frame_cnt_o = fcnt_q;
    assign busy_o      = busy_q;

endmodule

// File: tb/tb_bt656_tx_gen.sv
// Directed bench for bt656_tx_gen.
// It applies a hand-written 60-byte vector table, then runs frame streams against a line-based
// expected-stream builder, and scans every captured frame for timing-code and reserved-value rules.
module tb_bt656_tx_gen;

    logic        clk;
    logic        rst;
    logic        cfg_enable;
    logic [10:0] cfg_line_len;
    logic [10:0] cfg_lines;
    logic [7:0]  cfg_hblank;
    logic [7:0]  cfg_vblank;
    logic        cfg_emb;
    logic [7:0]  data_o;
    logic        href_o;
    logic        vsync_o;
    logic [15:0] frame_cnt_o;
    logic        busy_o;

    int errors;
    int checks;

    logic [7:0] ed[$];
    logic       eh[$];
    logic       ev[$];
    logic [7:0] cap[$];

    typedef struct {
        logic       en;
        logic [7:0] d;
        logic       h;
        logic       v;
    } vec_t;

    vec_t       tbl[60];
    logic [7:0] t1_d[60];

    bt656_tx_gen #(.CNT_W(11), .FCNT_W(16)) dut (
        .clk_i              (clk),
        .rst_i              (rst),
        .cfg_enable_i       (cfg_enable),
        .cfg_line_len_i     (cfg_line_len),
        .cfg_lines_i        (cfg_lines),
        .cfg_hblank_i       (cfg_hblank),
        .cfg_vblank_i       (cfg_vblank),
        .cfg_emb_frame_cnt_i(cfg_emb),
        .data_o             (data_o),
        .href_o             (href_o),
        .vsync_o            (vsync_o),
        .frame_cnt_o        (frame_cnt_o),
        .busy_o             (busy_o)
    );

    // Free-running clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    function automatic logic [7:0] clampb(input logic [7:0] b);
        if (b == 8'h00) return 8'h01;
        if (b == 8'hFF) return 8'hFE;
        return b;
    endfunction

    function automatic bit xy_ok(input logic [7:0] xy);
        logic v;
        logic h;
        v = xy[5];
        h = xy[4];
        return (xy[7] == 1'b1) && (xy[6] == 1'b0) && (xy[3] == (v ^ h)) &&
               (xy[2] == h) && (xy[1] == v) && (xy[0] == (v ^ h));
    endfunction

    task automatic push(input logic [7:0] d, input logic h, input logic v);
        ed.push_back(d);
        eh.push_back(h);
        ev.push_back(v);
    endtask

    // Expected stream, built line by line from the already-clamped frame parameters.
    task automatic build_exp(input int len, input int lines, input int hbl, input int vbl,
                             input bit emb, input int fc);
        logic [7:0] b;
        logic [7:0] cb;
        logic [7:0] rb;
        logic [15:0] f16;
        bit v;
        int r;
        ed.delete();
        eh.delete();
        ev.delete();
        f16 = fc[15:0];
        for (int l = 0; l < vbl + lines; l++) begin
            v = (l < vbl);
            r = l - vbl;
            push(8'hFF, 1'b0, v); push(8'h00, 1'b0, v); push(8'h00, 1'b0, v);
            push(v ? 8'hB6 : 8'h9D, 1'b0, v);
            for (int c = 0; c < hbl; c++) push((c % 2 == 0) ? 8'h80 : 8'h10, 1'b0, v);
            push(8'hFF, 1'b0, v); push(8'h00, 1'b0, v); push(8'h00, 1'b0, v);
            push(v ? 8'hAB : 8'h80, 1'b0, v);
            for (int c = 0; c < len; c++) begin
                if (v) begin
                    push((c % 2 == 0) ? 8'h80 : 8'h10, 1'b0, 1'b1);
                end else begin
                    cb = c[7:0];
                    rb = r[7:0];
                    b = cb ^ rb;
                    if (emb && r == 0 && c == 0) b = f16[15:8];
                    if (emb && r == 0 && c == 1) b = f16[7:0];
                    push(clampb(b), 1'b1, 1'b0);
                end
            end
        end
    endtask

    // Checks every captured FF as the start of FF 00 00 XY with valid protection bits; no stray 00/FF.
    task automatic scan_codes(input string nm);
        int i;
        int bad;
        bad = -1;
        i = 0;
        while (i < cap.size()) begin
            if (cap[i] == 8'hFF) begin
                if (i + 3 >= cap.size()) begin
                    if (bad < 0) bad = i;
                end else if (cap[i+1] != 8'h00 || cap[i+2] != 8'h00 || !xy_ok(cap[i+3])) begin
                    if (bad < 0) bad = i;
                end
                i += 4;
            end else begin
                if (cap[i] == 8'h00 && bad < 0) bad = i;
                i++;
            end
        end
        checks++;
        if (bad >= 0) begin
            errors++;
            $display("FAIL %s code_scan: got byte %h at index %0d, required FF 00 00 XY with valid parity and no other 00/FF",
                     nm, cap[bad], bad);
        end
    endtask

    // Clocks out one expected frame. It can change line_len or drop enable after a given byte.
    task automatic frame_cmp(input string nm, input int chg_at, input int chg_len, input int drop_at);
        int bad;
        logic [7:0] ad;
        logic ah, av, ab;
        bad = -1;
        ad = 8'h00; ah = 1'b0; av = 1'b0; ab = 1'b0;
        cap.delete();
        for (int i = 0; i < ed.size(); i++) begin
            step();
            cap.push_back(data_o);
            if (bad < 0 && (data_o !== ed[i] || href_o !== eh[i] || vsync_o !== ev[i] || busy_o !== 1'b1)) begin
                bad = i; ad = data_o; ah = href_o; av = vsync_o; ab = busy_o;
            end
            if (i == chg_at) cfg_line_len = chg_len[10:0];
            if (i == drop_at) cfg_enable = 1'b0;
        end
        checks++;
        if (bad >= 0) begin
            errors++;
            $display("FAIL %s stream byte %0d: got data=%h href=%b vsync=%b busy=%b, expected data=%h href=%b vsync=%b busy=1",
                     nm, bad, ad, ah, av, ab, ed[bad], eh[bad], ev[bad]);
        end
        scan_codes(nm);
    endtask

    task automatic set_cfg(input int len, input int lines, input int hbl, input int vbl, input bit emb);
        cfg_line_len = len[10:0];
        cfg_lines    = lines[10:0];
        cfg_hblank   = hbl[7:0];
        cfg_vblank   = vbl[7:0];
        cfg_emb      = emb;
    endtask

    task automatic chk_idle(input string nm, input int fc);
        chk({nm, "_data"}, {24'd0, data_o}, 32'h0000_0000);
        chk({nm, "_busy"}, {31'd0, busy_o}, 32'd0);
        chk({nm, "_vsync"}, {31'd0, vsync_o}, 32'd0);
        chk({nm, "_fcnt"}, {16'd0, frame_cnt_o}, fc);
    endtask

    // Directed test sequence.
    initial begin
        int fc;
        int rl, rn, rh, rv;
        bit re;
        errors = 0;
        checks = 0;
        rst = 1'b1;
        cfg_enable = 1'b0;
        set_cfg(8, 2, 4, 1, 1'b0);

        // Reset state
        step();
        step();
        chk("rst_data", {24'd0, data_o}, 32'd0);
        chk("rst_href", {31'd0, href_o}, 32'd0);
        chk("rst_vsync", {31'd0, vsync_o}, 32'd0);
        chk("rst_busy", {31'd0, busy_o}, 32'd0);
        chk("rst_fcnt", {16'd0, frame_cnt_o}, 32'd0);
        rst = 1'b0;
        step();
        chk("idle_data", {24'd0, data_o}, 32'd0);

        // Table: first frame, line_len=8 lines=2 hblank=4 vblank=1
        t1_d = '{8'hFF, 8'h00, 8'h00, 8'hB6, 8'h80, 8'h10, 8'h80, 8'h10, 8'hFF, 8'h00,
                 8'h00, 8'hAB, 8'h80, 8'h10, 8'h80, 8'h10, 8'h80, 8'h10, 8'h80, 8'h10,
                 8'hFF, 8'h00, 8'h00, 8'h9D, 8'h80, 8'h10, 8'h80, 8'h10, 8'hFF, 8'h00,
                 8'h00, 8'h80, 8'h01, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07,
                 8'hFF, 8'h00, 8'h00, 8'h9D, 8'h80, 8'h10, 8'h80, 8'h10, 8'hFF, 8'h00,
                 8'h00, 8'h80, 8'h01, 8'h01, 8'h03, 8'h02, 8'h05, 8'h04, 8'h07, 8'h06};
        for (int i = 0; i < 60; i++) begin
            tbl[i].en = (i < 5);
            tbl[i].d  = t1_d[i];
            tbl[i].h  = ((i >= 32 && i <= 39) || (i >= 52 && i <= 59));
            tbl[i].v  = (i < 20);
        end
        for (int i = 0; i < 60; i++) begin
            cfg_enable = tbl[i].en;
            step();
            checks++;
            if (data_o !== tbl[i].d || href_o !== tbl[i].h || vsync_o !== tbl[i].v) begin
                errors++;
                $display("FAIL tbl[%0d]: got data=%h href=%b vsync=%b expected data=%h href=%b vsync=%b",
                         i, data_o, href_o, vsync_o, tbl[i].d, tbl[i].h, tbl[i].v);
            end
        end
        chk("t1_fcnt_last", {16'd0, frame_cnt_o}, 32'd1);
        step();
        chk_idle("t1_after", 1);

        // Odd and minimum sizes: 7 becomes 6 bytes, 0 lines becomes 1, no hblank, no vblank
        set_cfg(7, 0, 0, 0, 1'b0);
        cfg_enable = 1'b1;
        build_exp(6, 1, 0, 0, 1'b0, 1);
        frame_cmp("min", -1, 0, 0);
        chk("min_sav_follows_eav", {24'd0, cap[4]}, 32'h0000_00FF);
        chk("min_len", cap.size(), 32'd14);
        step();
        chk_idle("min_after", 2);

        // Continuous enable over three frames, with a mid-frame line_len change
        rst = 1'b1;
        step();
        rst = 1'b0;
        set_cfg(4, 2, 2, 1, 1'b0);
        cfg_enable = 1'b1;
        build_exp(4, 2, 2, 1, 1'b0, 0);
        frame_cmp("cont1", 10, 10, -1);
        chk("cont1_fcnt", {16'd0, frame_cnt_o}, 32'd1);
        build_exp(10, 2, 2, 1, 1'b0, 1);
        frame_cmp("cont2", -1, 0, -1);
        chk("cont2_fcnt", {16'd0, frame_cnt_o}, 32'd2);
        build_exp(10, 2, 2, 1, 1'b0, 2);
        frame_cmp("cont3", -1, 0, 3);
        chk("cont3_fcnt", {16'd0, frame_cnt_o}, 32'd3);
        step();
        chk_idle("cont_after", 3);

        // 255 minimum frames, then one frame with the embedded counter 0x00FF
        rst = 1'b1;
        step();
        rst = 1'b0;
        set_cfg(0, 0, 0, 0, 1'b0);
        cfg_enable = 1'b1;
        for (int k = 0; k < 255; k++) begin
            build_exp(2, 1, 0, 0, 1'b0, k);
            frame_cmp("minrun", -1, 0, -1);
        end
        chk("minrun_fcnt", {16'd0, frame_cnt_o}, 32'h0000_00FF);
        set_cfg(8, 2, 0, 0, 1'b1);
        build_exp(8, 2, 0, 0, 1'b1, 255);
        frame_cmp("emb", -1, 0, 14);
        chk("emb_byte0", {24'd0, cap[8]}, 32'h0000_0001);
        chk("emb_byte1", {24'd0, cap[9]}, 32'h0000_00FE);
        chk("emb_fcnt", {16'd0, frame_cnt_o}, 32'h0000_0100);
        step();
        chk_idle("emb_after", 256);

        // Reset asserted mid-payload
        set_cfg(8, 1, 0, 0, 1'b0);
        cfg_enable = 1'b1;
        for (int i = 0; i < 10; i++) step();
        chk("midrst_href_before", {31'd0, href_o}, 32'd1);
        rst = 1'b1;
        step();
        chk("midrst_data", {24'd0, data_o}, 32'd0);
        chk("midrst_href", {31'd0, href_o}, 32'd0);
        chk("midrst_busy", {31'd0, busy_o}, 32'd0);
        chk("midrst_fcnt", {16'd0, frame_cnt_o}, 32'd0);
        rst = 1'b0;
        cfg_enable = 1'b0;
        step();
        chk("postrst_data", {24'd0, data_o}, 32'd0);
        chk("postrst_busy", {31'd0, busy_o}, 32'd0);

        // Random configurations back to back, config changed between frames
        fc = 0;
        cfg_enable = 1'b1;
        for (int it = 0; it < 100; it++) begin
            rl = $urandom_range(0, 24);
            rn = $urandom_range(0, 4);
            rh = $urandom_range(0, 9);
            rv = $urandom_range(0, 3);
            re = 1'($urandom_range(0, 1));
            set_cfg(rl, rn, rh, rv, re);
            build_exp(((rl & ~1) < 2) ? 2 : (rl & ~1), (rn == 0) ? 1 : rn, rh, rv, re, fc);
            frame_cmp("rand", -1, 0, (it == 99) ? 0 : -1);
            fc++;
        end
        step();
        chk_idle("rand_after", 100);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/bt656_tx_gen.md
Name: bt656_tx_gen

Overview:
- BT.656-style 8-bit video stream generator. It is the transmit-side counterpart of the camera RX path.
- Emits embedded SAV/EAV timing codes, blanking fill and a deterministic test pattern, plus href/vsync side signals.
- Used as a loopback source to drive the RX capture path and its data FIFO, both in pure-BT.656 mode and in control-signal mode, without a camera attached.
- Configuration comes from the AXI4-Lite register block, in the same clock domain.

Parameters:
- CNT_W, 11, width of the line-length and line-count configuration fields.
- FCNT_W, 16, width of the frame counter.

Ports:
- clk_i  in  1  system clock; one output byte per cycle.
- rst_i  in  1  synchronous, active-high reset.
- cfg_enable_i  in  1  generator enable, sampled only at frame boundaries.
- cfg_line_len_i  in  CNT_W  active payload bytes per line; LSB is ignored (forced even).
- cfg_lines_i  in  CNT_W  active lines per frame.
- cfg_hblank_i  in  8  horizontal blanking fill bytes between EAV and SAV.
- cfg_vblank_i  in  8  vertical blanking lines before the active lines.
- cfg_emb_frame_cnt_i  in  1  embed the frame counter in the first 2 payload bytes of active line 0.
- data_o  out  8  stream byte.
- href_o  out  1  high on payload bytes of active lines.
- vsync_o  out  1  high for every byte of vertical blanking lines.
- frame_cnt_o  out  FCNT_W  number of completed frames.
- busy_o  out  1  high whenever the FSM is not in IDLE.

Behaviour:
- Reset: all outputs 0; FSM to IDLE; counters 0. A reset mid-frame aborts the frame immediately, and the next byte after reset deassertion is 0x00.
- All outputs are registered.
- Config latch:
  - All cfg_* fields are captured in IDLE at frame start and held for the whole frame.
  - Clamps applied at capture: line_len < 2 -> 2; lines == 0 -> 1.
  - hblank = 0 and vblank = 0 are legal.
- FSM states: IDLE, EAV, HBLANK, SAV, PAYLOAD.
  - IDLE -> EAV when cfg_enable_i = 1. The first 0xFF appears on data_o in the cycle after enable is sampled.
  - EAV (4 bytes) -> HBLANK, or -> SAV if hblank = 0.
  - HBLANK (hblank bytes) -> SAV.
  - SAV (4 bytes) -> PAYLOAD.
  - PAYLOAD (line_len bytes) -> EAV of the next line.
  - After the last active line: -> IDLE if cfg_enable_i = 0, otherwise -> EAV of a new frame with config relatched. This is a zero-gap frame restart.
  - Deasserting enable mid-frame completes the current frame first.
- Line order: vblank lines (V=1) first, then active lines (V=0). F = 0 always (progressive).
- Timing code bytes: FF 00 00 XY, where XY = {1, F, V, H, V^H, F^H, F^V, F^V^H}. This gives:
  - active SAV = 0x80, active EAV = 0x9D;
  - blank SAV = 0xAB, blank EAV = 0xB6.
- Fill bytes:
  - HBLANK fill, and PAYLOAD fill on blank lines, alternate 0x80, 0x10, starting with 0x80.
  - HBLANK byte count is exact even if it is odd.
- Active payload:
  - Byte at column c, active line r = c[7:0] ^ r[7:0].
  - Values 0x00 are replaced by 0x01; values 0xFF are replaced by 0xFE. No reserved codes appear in the payload.
  - If emb_frame_cnt is set, bytes 0 and 1 of active line 0 are frame_cnt[15:8] and frame_cnt[7:0], with the same clamp applied.
- Side signals:
  - href_o is high exactly during PAYLOAD on active lines.
  - vsync_o is high for every state of a vblank line, EAV through PAYLOAD.
- Frame counter: increments by 1 on the last payload byte of the last active line. It wraps from 0xFFFF to 0x0000. It is not reset by enable toggling.
- In IDLE: data_o = 0x00, href_o = 0, vsync_o = 0.

Test Plan:
- Reset, then enable with line_len=8, lines=2, hblank=4, vblank=1, emb=0.
  - Required sequence: FF 00 00 B6, 80 10 80 10, FF 00 00 AB, 8 fill bytes with vsync=1; then FF 00 00 9D, 4 fill bytes, FF 00 00 80, 01 01 02 03 04 05 06 07 with href=1.
  - Total frame = 60 bytes, then IDLE if enable is low; frame_cnt_o = 1.
- Odd and minimum sizes: line_len=7 -> 6 payload bytes; lines=0 -> 1 active line; hblank=0 -> SAV directly follows EAV; vblank=0 -> no vsync.
- Continuous enable over 3 frames:
  - No IDLE cycle between frames; frame_cnt_o steps 1, 2, 3.
  - A line_len change made mid-frame takes effect only from the next frame.
- emb=1 with frame_cnt preloaded to 0x00FF by running 255 frames of minimum size: active line 0 starts with 01 FE (0x00 and 0xFF clamped).
- Enable dropped mid-payload completes the frame. rst_i asserted mid-payload gives data_o = 0x00, href_o = 0, busy_o = 0 on the next cycle.
- Scoreboard: check every XY byte against the parity formula over 100 random configs. No 0x00 or 0xFF may appear outside the timing codes.
